demux_feeder: RTL and testbench
===============================

DEMUX_FEEDER -- requirements
Module: demux_feeder

Interface
REQ-001: Parameter DW, default 4, SHALL set the data word width and match the 1:4 demux data input.
REQ-002: Parameter DEPTH, default 4, SHALL set the FIFO entry count; it is a power of two, at least 2.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst  input  1  reset; asynchronous and active-high.
REQ-005: flush  input  1  synchronous discard of all buffered and presented words.
REQ-006: in_data  input  DW  word to be routed.
REQ-007: in_dest  input  2  destination channel for in_data: 0..3, maps to {s1,s0}.
REQ-008: in_valid  input  1  in_data and in_dest are valid.
REQ-009: in_ready  output  1  block can accept a word this cycle.
REQ-010: ch_busy  input  4  bit n high means channel n cannot take a word this cycle.
REQ-011: a  output  DW  registered data to the demux.
REQ-012: s1, s0  output  1 each  registered channel select to the demux; s1 is the MSB.
REQ-013: a_valid  output  1  registered; a and {s1,s0} carry a word this cycle.
REQ-014: blocked  output  1  registered; the FIFO head is stalled by ch_busy.
REQ-015: stall_cnt  output  8  saturating count of blocked cycles.

Function
REQ-016: The block SHALL hold {in_dest,in_data} entries in a DEPTH-entry FIFO with a count register of clog2(DEPTH)+1 bits.
REQ-017: Push: a push SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-018: in_ready SHALL be combinationally (count<DEPTH) and not rst and not flush.
REQ-019: Full FIFO: in_ready SHALL be 0, with no same-cycle pass-through.
REQ-020: Pop: when count>0 and ch_busy[head dest]==0, the head SHALL be popped.
REQ-021: After each pop edge: a=head data, {s1,s0}=head dest, a_valid=1.
REQ-022: Cycle after a non-pop edge: a=0, a_valid=0, {s1,s0} hold their last value, so all demux outputs read 0.
REQ-023: Latency: a word pushed at edge k into an empty FIFO, with its channel not busy, SHALL appear with a_valid=1 after edge k+1.
REQ-024: Throughput: one word per cycle sustained.
REQ-025: Simultaneous push and pop SHALL leave count unchanged.
REQ-026: Pointers SHALL wrap modulo DEPTH.
REQ-027: Ordering SHALL be strict FIFO; a busy head blocks later words even when their channels are free (head-of-line).
REQ-028: State machine, registered, with three states:
 - IDLE: count==0.
 - RUN: pop this cycle.
 - BLOCKED: count>0 and head channel busy.
REQ-029: Next state SHALL be evaluated each edge from post-update conditions.
REQ-030: blocked SHALL be 1 exactly while the state is BLOCKED.
REQ-031: stall_cnt SHALL increment on each edge where the pre-edge condition is BLOCKED.
REQ-032: stall_cnt SHALL saturate at 255 and clear only on rst or flush.
REQ-033: Flush SHALL have priority over push and pop.
REQ-034: At a flush edge: count=0, pointers=0, a=0, a_valid=0, blocked=0, stall_cnt=0, state=IDLE; {s1,s0} hold.
REQ-035: A push or pop in a flush cycle SHALL be discarded.
REQ-036: ch_busy changes SHALL take effect on the same edge; no registering of ch_busy.

Reset
REQ-037: While rst=1: count=0, pointers=0, a=0, s1=0, s0=0, a_valid=0, blocked=0, stall_cnt=0, state=IDLE, in_ready=0.
REQ-038: FIFO storage contents need not be reset.
REQ-039: Reset asserted mid-operation SHALL drop all buffered words immediately, without waiting for a clock edge.
REQ-040: After rst deasserts, in_ready SHALL be 1 and the first push SHALL be accepted on the first rising edge.

Verification
REQ-041: Single word: push data=4'hA, dest=2 into an empty FIFO, ch_busy=0 -> the next cycle a=4'hA, {s1,s0}=2'b10, a_valid=1; the cycle after, a=0, a_valid=0.
REQ-042: Fill: ch_busy=4'hF, push 5 words back-to-back -> in_ready drops after the 4th word, and the 5th is held off.
REQ-043: Blocked then drain: stall_cnt counts the blocked cycles; after ch_busy=0, the 4 words emerge in order on 4 consecutive cycles.
REQ-044: Head-of-line: queue dest 1 then dest 3 with ch_busy=4'b0010 -> nothing emitted and blocked=1; clearing bit 1 releases dest 1, then dest 3 on the following cycle.
REQ-045: Saturation and flush: hold BLOCKED for 300 cycles -> stall_cnt=255; flush -> count=0, stall_cnt=0, a_valid=0, in_ready=1 the next cycle.
REQ-046: Async reset: assert rst between edges with 3 words queued and a_valid=1 -> a=0, a_valid=0, in_ready=0 immediately; after release, no stale word is emitted.

Source files
------------

// File: rtl/demux_feeder.sv
// FIFO-buffered feeder for a 1:4 demux: queues {dest,data} words and presents them
// on registered a/{s1,s0}/a_valid when the destination channel is free.
module demux_feeder #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] in_data,
    input  logic [1:0]    in_dest,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    ch_busy,
    output logic [DW-1:0] a,
    output logic          s1,
    output logic          s0,
    output logic          a_valid,
    output logic          blocked,
    output logic [7:0]    stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DW + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BLOCKED} state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] a_q, a_d;
    logic [1:0]    sel_q, sel_d;
    logic          a_valid_q, a_valid_d;
    logic [7:0]    stall_q, stall_d;
    state_t        state_q, state_d;

    logic [EW-1:0] head_c;
    logic [EW-1:0] after_head_c;
    logic [1:0]    next_dest_c;
    logic          push_c;
    logic          pop_c;
    logic          stall_c;

    assign in_ready     = (count_q < CW'(DEPTH)) && !rst && !flush;
    assign push_c       = in_valid && in_ready;
    assign head_c       = mem_q[rd_ptr_q];
    assign after_head_c = mem_q[AW'(rd_ptr_q + AW'(1))];
    assign stall_c      = (count_q != '0) && ch_busy[head_c[EW-1 -: 2]];
    assign pop_c        = (count_q != '0) && !stall_c && !flush;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= {in_dest, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            a_q       <= '0;
            sel_q     <= '0;
            a_valid_q <= 1'b0;
            stall_q   <= '0;
            state_q   <= S_IDLE;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            a_q       <= a_d;
            sel_q     <= sel_d;
            a_valid_q <= a_valid_d;
            stall_q   <= stall_d;
            state_q   <= state_d;
        end
    end

    // Next-state: FIFO bookkeeping, output word, stall counter and FSM.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        a_d         = '0;
        sel_d       = sel_q;
        a_valid_d   = 1'b0;
        stall_d     = stall_q;
        state_d     = state_q;
        next_dest_c = head_c[EW-1 -: 2];

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            stall_d  = '0;
            state_d  = S_IDLE;
        end else begin
            if (stall_c && (stall_q != 8'hFF)) begin
                stall_d = stall_q + 8'd1;
            end
            if (pop_c) begin
                a_d       = head_c[DW-1:0];
                sel_d     = head_c[EW-1 -: 2];
                a_valid_d = 1'b1;
                rd_ptr_d  = AW'(rd_ptr_q + AW'(1));
            end
            if (push_c) begin
                wr_ptr_d = AW'(wr_ptr_q + AW'(1));
            end
            count_d = CW'(count_q + CW'(push_c) - CW'(pop_c));

            // Head after this edge: a word pushed into an empty slot becomes head.
            if (pop_c) begin
                next_dest_c = (count_q == CW'(1)) ? in_dest : after_head_c[EW-1 -: 2];
            end else if (count_q == '0) begin
                next_dest_c = in_dest;
            end

            if (count_d == '0) begin
                state_d = S_IDLE;
            end else if (ch_busy[next_dest_c]) begin
                state_d = S_BLOCKED;
            end else begin
                state_d = S_RUN;
            end
        end
    end

    assign a         = a_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];
    assign a_valid   = a_valid_q;
    assign blocked   = (state_q == S_BLOCKED);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_demux_feeder.sv
// Directed bench for demux_feeder with a queue-based reference model used as scoreboard.
module tb_demux_feeder;

    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ch_busy;
    logic [DW-1:0] a;
    logic          s1;
    logic          s0;
    logic          a_valid;
    logic          blocked;
    logic [7:0]    stall_cnt;

    demux_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_busy   (ch_busy),
        .a         (a),
        .s1        (s1),
        .s0        (s0),
        .a_valid   (a_valid),
        .blocked   (blocked),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    d;
        logic [DW-1:0] w;
    } ent_t;

    ent_t          sb[$];
    logic [DW-1:0] m_a     = '0;
    logic [1:0]    m_sel   = '0;
    logic          m_av    = 1'b0;
    logic          m_blk   = 1'b0;
    logic [7:0]    m_stall = '0;
    int            checks  = 0;
    int            errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one rising edge, evaluated with the pre-edge inputs.
    task automatic model_edge();
        bit   blk;
        bit   pop;
        bit   push;
        ent_t e;
        if (rst) return;
        push = in_valid && (sb.size() < DEPTH) && !flush;
        if (flush) begin
            sb.delete();
            m_a     = '0;
            m_av    = 1'b0;
            m_stall = '0;
            m_blk   = 1'b0;
            return;
        end
        blk = (sb.size() > 0) && ch_busy[sb[0].d];
        pop = (sb.size() > 0) && !blk;
        if (blk && m_stall != 8'd255) m_stall++;
        if (pop) begin
            e     = sb.pop_front();
            m_a   = e.w;
            m_sel = e.d;
            m_av  = 1'b1;
        end else begin
            m_a  = '0;
            m_av = 1'b0;
        end
        if (push) begin
            e.d = in_dest;
            e.w = in_data;
            sb.push_back(e);
        end
        m_blk = (sb.size() > 0) && ch_busy[sb[0].d];
    endtask

    task automatic check_all(input string tag);
        logic exp_rdy;
        exp_rdy = (sb.size() < DEPTH) && !rst && !flush;
        chk({tag, "/a_valid"}, 32'(a_valid), 32'(m_av));
        chk({tag, "/a"}, 32'(a), 32'(m_a));
        chk({tag, "/sel"}, 32'({s1, s0}), 32'(m_sel));
        chk({tag, "/blocked"}, 32'(blocked), 32'(m_blk));
        chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        chk({tag, "/in_ready"}, 32'(in_ready), 32'(exp_rdy));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] seen [4];

        rst      = 1'b1;
        flush    = 1'b0;
        in_data  = '0;
        in_dest  = '0;
        in_valid = 1'b0;
        ch_busy  = '0;
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_reset_ready", 32'(in_ready), 32'd1);

        // Single word through an idle channel.
        in_valid = 1'b1; in_data = 4'hA; in_dest = 2'd2;
        step("sw_push");
        in_valid = 1'b0;
        step("sw_out");
        chk("sw_a", 32'(a), 32'h0000000A);
        chk("sw_sel", 32'({s1, s0}), 32'd2);
        step("sw_gap");

        // Fill with all channels busy; fifth word must be refused.
        ch_busy = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            in_dest  = 2'(i);
            chk($sformatf("fill_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            step($sformatf("fill%0d", i));
        end
        in_valid = 1'b0;
        repeat (3) step("fill_hold");
        chk("fill_stall", 32'(stall_cnt), 32'd7);
        chk("fill_blocked", 32'(blocked), 32'd1);

        // Drain in order on consecutive cycles.
        ch_busy = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("drain%0d", i));
            seen[i] = a;
            chk($sformatf("drain_av%0d", i), 32'(a_valid), 32'd1);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("drain_order%0d", i), 32'(seen[i]), 32'(i + 1));
        step("drain_empty");

        // Head-of-line: busy dest 1 holds back dest 3.
        ch_busy  = 4'b0010;
        in_valid = 1'b1; in_data = 4'h5; in_dest = 2'd1;
        step("hol_push1");
        in_data = 4'h6; in_dest = 2'd3;
        step("hol_push3");
        in_valid = 1'b0;
        step("hol_wait");
        chk("hol_blocked", 32'(blocked), 32'd1);
        chk("hol_noout", 32'(a_valid), 32'd0);
        ch_busy = 4'h0;
        step("hol_rel1");
        chk("hol_first", 32'({s1, s0, a}), 32'({2'd1, 4'h5}));
        step("hol_rel3");
        chk("hol_second", 32'({s1, s0, a}), 32'({2'd3, 4'h6}));
        step("hol_idle");

        // Saturate stall counter, then flush.
        ch_busy  = 4'hF;
        in_valid = 1'b1; in_data = 4'h9; in_dest = 2'd0;
        step("sat_push");
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) step("sat");
        chk("sat_255", 32'(stall_cnt), 32'd255);
        flush = 1'b1;
        step("flush");
        chk("flush_stall", 32'(stall_cnt), 32'd0);
        flush = 1'b0;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd1);
        ch_busy = 4'h0;
        step("flush_empty");

        // Asynchronous reset with words queued and a word on the output.
        ch_busy  = 4'hF;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = DW'(4'hC + i);
            in_dest = 2'(3 - i);
            step($sformatf("ar_fill%0d", i));
        end
        in_valid = 1'b0;
        ch_busy  = 4'h0;
        step("ar_pop");
        chk("ar_pre_av", 32'(a_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        m_a = '0; m_sel = '0; m_av = 1'b0; m_blk = 1'b0; m_stall = '0;
        check_all("arst");
        chk("arst_av", 32'(a_valid), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step("ar_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
